// File: rtl/pwm_seq_ctrl.sv
// PWM compare-value sequencer: buffers {repeat, 4 x compare} entries in a circular
// FIFO and applies them to the PWM channels one period boundary at a time.
module pwm_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      en_i,
  input  logic                      loop_i,
  input  logic                      clr_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [4*DATA_WIDTH-1:0]   wr_data_i,
  input  logic [7:0]                wr_rpt_i,
  input  logic                      period_end_i,
  output logic [4*DATA_WIDTH-1:0]   crr_o,
  output logic                      crr_upd_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [$clog2(DEPTH):0]    level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = 4 * DATA_WIDTH;
  localparam int EW = DW + 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    rpt_q, rpt_d;
  logic [DW-1:0] crr_q, crr_d;
  logic          upd_q, upd_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [EW-1:0] mem_q [DEPTH];

  logic          full_s;
  logic          empty_s;
  logic [EW-1:0] head_s;
  logic [DW-1:0] head_data_s;
  logic [7:0]    head_rpt_s;
  logic          load_s;
  logic          push_s;
  logic          recirc_s;
  logic          mem_we_s;
  logic [EW-1:0] mem_wdata_s;

  assign full_s      = (count_q == CW'(DEPTH));
  assign empty_s     = (count_q == {CW{1'b0}});
  assign head_s      = mem_q[rptr_q];
  assign head_data_s = head_s[DW-1:0];
  assign head_rpt_s  = head_s[EW-1 -: 8];

  // Writers are held off while looping so the recirculated entry owns the tail slot.
  assign wr_ready_o = !full_s && !(loop_i && busy_q);

  assign crr_o     = crr_q;
  assign crr_upd_o = upd_q;
  assign done_o    = done_q;
  assign busy_o    = busy_q;
  assign level_o   = count_q;

  // Sequencer FSM and output next-state; clr_i beats en_i, which beats period_end_i.
  always_comb begin
    state_d = state_q;
    rpt_d   = rpt_q;
    crr_d   = crr_q;
    upd_d   = 1'b0;
    done_d  = 1'b0;
    load_s  = 1'b0;
    if (clr_i) begin
      state_d = ST_IDLE;
      rpt_d   = 8'd0;
    end else if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!empty_s) begin
            state_d = ST_ARM;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARM: begin
          if (period_end_i && !empty_s) begin
            load_s = 1'b1;
          end else begin
            load_s = 1'b0;
          end
        end
        ST_HOLD: begin
          if (period_end_i) begin
            if (rpt_q != 8'd0) begin
              rpt_d = rpt_q - 8'd1;
            end else if (!empty_s) begin
              load_s = 1'b1;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    if (load_s) begin
      state_d = ST_HOLD;
      crr_d   = head_data_s;
      rpt_d   = head_rpt_s;
      upd_d   = 1'b1;
    end else begin
      upd_d   = upd_d;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // FIFO pointer/count next-state; a loop-mode pop writes the head straight back to the tail.
  always_comb begin
    push_s      = wr_valid_i && wr_ready_o && !clr_i;
    recirc_s    = load_s && loop_i;
    mem_we_s    = push_s || recirc_s;
    mem_wdata_s = recirc_s ? head_s : {wr_rpt_i, wr_data_i};
    if (clr_i) begin
      wptr_d  = {AW{1'b0}};
      rptr_d  = {AW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      wptr_d  = wptr_q + {{(AW-1){1'b0}}, mem_we_s};
      rptr_d  = rptr_q + {{(AW-1){1'b0}}, load_s};
      count_d = count_q + {{(CW-1){1'b0}}, mem_we_s} - {{(CW-1){1'b0}}, load_s};
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
      rpt_q   <= 8'd0;
      crr_q   <= {DW{1'b0}};
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rpt_q   <= rpt_d;
      crr_q   <= crr_d;
      upd_q   <= upd_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
    end else if (mem_we_s) begin
      mem_q[wptr_q] <= mem_wdata_s;
    end else begin
      mem_q[wptr_q] <= mem_q[wptr_q];
    end
  end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Scenario bench for pwm_seq_ctrl: expected compare loads are queued when the
// period pulse is driven and popped by a monitor when crr_upd_o fires.
module tb_pwm_seq_ctrl;

  localparam int DW = 16;
  localparam int DEPTH = 8;

  logic          clk_i;
  logic          rst_n_i;
  logic          en_i;
  logic          loop_i;
  logic          clr_i;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [63:0]   wr_data_i;
  logic [7:0]    wr_rpt_i;
  logic          period_end_i;
  logic [63:0]   crr_o;
  logic          crr_upd_o;
  logic          busy_o;
  logic          done_o;
  logic [3:0]    level_o;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [63:0] exp_q [$];

  localparam logic [63:0] VAL_A = {16'd400, 16'd300, 16'd200, 16'd100};
  localparam logic [63:0] VAL_B = {16'd50, 16'd50, 16'd50, 16'd50};

  pwm_seq_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .loop_i(loop_i), .clr_i(clr_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .wr_rpt_i(wr_rpt_i), .period_end_i(period_end_i), .crr_o(crr_o),
    .crr_upd_o(crr_upd_o), .busy_o(busy_o), .done_o(done_o), .level_o(level_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Scoreboard monitor: every crr_upd_o must match the oldest queued expectation.
  always @(negedge clk_i) begin
    logic [63:0] exp_v;
    if (done_o === 1'b1) done_cnt++;
    if (crr_upd_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL upd_unexpected: crr_o=%h, required no update", crr_o);
      end else begin
        exp_v = exp_q.pop_front();
        if (crr_o !== exp_v) begin
          errors++;
          $display("FAIL upd_value: crr_o=%h, required %h", crr_o, exp_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic write_entry(input logic [63:0] d, input logic [7:0] r);
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    wr_rpt_i   = r;
    @(negedge clk_i);
    wr_valid_i = 1'b0;
  endtask

  task automatic pulse(input logic exp_load, input logic [63:0] exp_val);
    if (exp_load) exp_q.push_back(exp_val);
    period_end_i = 1'b1;
    @(negedge clk_i);
    period_end_i = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (crr_o !== 64'd0 || crr_upd_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 ||
        level_o !== 4'd0 || wr_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: crr=%h upd=%b done=%b busy=%b level=%0d ready=%b, required 0/0/0/0/0/1",
               crr_o, crr_upd_o, done_o, busy_o, level_o, wr_ready_o);
    end
  endtask

  task automatic test_basic;
    int d0;
    en_i = 1'b0;
    write_entry(VAL_A, 8'd0);
    write_entry(VAL_B, 8'd1);
    checks++;
    if (level_o !== 4'd2) begin errors++; $display("FAIL basic_level: level=%0d, required 2", level_o); end
    en_i = 1'b1;
    tick(1);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy: busy=%b, required 1", busy_o); end
    tick(2);
    pulse(1'b1, VAL_A);
    tick(2);
    pulse(1'b1, VAL_B);
    tick(2);
    pulse(1'b0, 64'd0);
    tick(2);
    checks++;
    if (crr_o !== VAL_B || busy_o !== 1'b1) begin
      errors++; $display("FAIL basic_hold: crr=%h busy=%b, required %h 1", crr_o, busy_o, VAL_B);
    end
    d0 = done_cnt;
    period_end_i = 1'b1;
    @(negedge clk_i);
    period_end_i = 1'b0;
    checks++;
    if (done_o !== 1'b1) begin errors++; $display("FAIL basic_done: done=%b, required 1", done_o); end
    tick(1);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL basic_after: done=%b busy=%b pulses=%0d, required 0 0 1", done_o, busy_o, done_cnt - d0);
    end
    en_i = 1'b0;
    tick(1);
  endtask

  task automatic test_full;
    en_i = 1'b0;
    for (int i = 0; i < 8; i++) write_entry({4{16'(i + 1)}}, 8'd0);
    checks++;
    if (level_o !== 4'd8 || wr_ready_o !== 1'b0) begin
      errors++; $display("FAIL full_level: level=%0d ready=%b, required 8 0", level_o, wr_ready_o);
    end
    write_entry({4{16'hFFFF}}, 8'd0);
    checks++;
    if (level_o !== 4'd8) begin errors++; $display("FAIL full_ignore: level=%0d, required 8", level_o); end
    en_i = 1'b1;
    tick(2);
    pulse(1'b1, {4{16'd1}});
    checks++;
    if (level_o !== 4'd7 || wr_ready_o !== 1'b1) begin
      errors++; $display("FAIL full_pop: level=%0d ready=%b, required 7 1", level_o, wr_ready_o);
    end
    for (int i = 2; i <= 8; i++) begin
      tick(1);
      pulse(1'b1, {4{16'(i)}});
    end
    tick(1);
    pulse(1'b0, 64'd0);
    tick(1);
    checks++;
    if (busy_o !== 1'b0 || level_o !== 4'd0) begin
      errors++; $display("FAIL full_drain: busy=%b level=%0d, required 0 0", busy_o, level_o);
    end
    en_i = 1'b0;
  endtask

  task automatic test_loop;
    int d0;
    en_i = 1'b0;
    loop_i = 1'b0;
    write_entry(VAL_A, 8'd0);
    write_entry(VAL_B, 8'd0);
    loop_i = 1'b1;
    en_i = 1'b1;
    d0 = done_cnt;
    tick(1);
    checks++;
    if (wr_ready_o !== 1'b0) begin errors++; $display("FAIL loop_ready: ready=%b, required 0", wr_ready_o); end
    for (int k = 0; k < 5; k++) begin
      tick(1);
      pulse(1'b1, (k % 2 == 1) ? VAL_B : VAL_A);
      checks++;
      if (level_o !== 4'd2) begin errors++; $display("FAIL loop_level: level=%0d, required 2", level_o); end
    end
    tick(2);
    en_i = 1'b0;
    tick(2);
    checks++;
    if (busy_o !== 1'b0 || level_o !== 4'd2 || crr_o !== VAL_A || done_cnt != d0) begin
      errors++; $display("FAIL loop_stop: busy=%b level=%0d crr=%h done_pulses=%0d, required 0 2 %h 0",
                         busy_o, level_o, crr_o, done_cnt - d0, VAL_A);
    end
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    loop_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) write_entry({4{16'(16'h1000 + i)}}, 8'd0);
    en_i = 1'b1;
    tick(2);
    exp_q.push_back({4{16'h1000}});
    period_end_i = 1'b1;
    wr_valid_i = 1'b1;
    wr_data_i = {4{16'h1003}};
    wr_rpt_i = 8'd0;
    @(negedge clk_i);
    period_end_i = 1'b0;
    wr_valid_i = 1'b0;
    checks++;
    if (level_o !== 4'd3) begin errors++; $display("FAIL b2b_level: level=%0d, required 3", level_o); end
    for (int i = 1; i < 4; i++) begin
      tick(1);
      pulse(1'b1, {4{16'(16'h1000 + i)}});
    end
    tick(1);
    pulse(1'b0, 64'd0);
    tick(1);
    checks++;
    if (busy_o !== 1'b0 || level_o !== 4'd0) begin
      errors++; $display("FAIL b2b_end: busy=%b level=%0d, required 0 0", busy_o, level_o);
    end
    en_i = 1'b0;
  endtask

  task automatic test_clr_hold;
    write_entry({4{16'h0C01}}, 8'd3);
    write_entry({4{16'h0C02}}, 8'd0);
    en_i = 1'b1;
    tick(2);
    pulse(1'b1, {4{16'h0C01}});
    tick(1);
    clr_i = 1'b1;
    period_end_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    period_end_i = 1'b0;
    checks++;
    if (crr_upd_o !== 1'b0 || crr_o !== {4{16'h0C01}} || level_o !== 4'd0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL clr_hold: upd=%b crr=%h level=%0d busy=%b, required 0 %h 0 0",
                         crr_upd_o, crr_o, level_o, busy_o, {4{16'h0C01}});
    end
    tick(1);
    pulse(1'b0, 64'd0);
    tick(1);
    en_i = 1'b0;
  endtask

  task automatic test_reset_mid;
    int d0;
    for (int i = 0; i < 5; i++) write_entry({4{16'(16'h0F00 + i)}}, 8'd2);
    en_i = 1'b1;
    tick(2);
    pulse(1'b1, {4{16'h0F00}});
    tick(1);
    checks++;
    if (level_o !== 4'd4 || busy_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: level=%0d busy=%b, required 4 1", level_o, busy_o);
    end
    d0 = done_cnt;
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if (crr_o !== 64'd0 || level_o !== 4'd0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
        crr_upd_o !== 1'b0 || wr_ready_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_async: crr=%h level=%0d busy=%b done=%b upd=%b ready=%b, required 0 0 0 0 0 1",
                         crr_o, level_o, busy_o, done_o, crr_upd_o, wr_ready_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick(1);
    for (int k = 0; k < 3; k++) begin
      pulse(1'b0, 64'd0);
      tick(1);
    end
    checks++;
    if (crr_o !== 64'd0 || done_cnt != d0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_after: crr=%h done_pulses=%0d busy=%b, required 0 0 0", crr_o, done_cnt - d0, busy_o);
    end
    en_i = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0;
    en_i = 1'b0;
    loop_i = 1'b0;
    clr_i = 1'b0;
    wr_valid_i = 1'b0;
    wr_data_i = 64'd0;
    wr_rpt_i = 8'd0;
    period_end_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    rst_n_i = 1'b1;
    tick(2);
    test_basic();
    test_full();
    test_loop();
    test_back_to_back();
    test_clr_hold();
    test_reset_mid();
    tick(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d expected loads never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
